// File: rtl/wash_cycle_controller_if.sv
// Command/status bundle between a wash-cycle controller and its host.
// Master drives start/abort/pause and presets; slave returns state, count and actuators.
interface wash_cycle_controller_if;
    logic       start;
    logic       abort;
    logic       pause;
    logic [4:0] wash;
    logic [4:0] rinse;
    logic [4:0] spin;
    logic [4:0] cloth;
    logic [3:0] state;
    logic [4:0] remaining;
    logic       valve_in;
    logic       motor;
    logic       spin_hi;
    logic       drain_pump;
    logic       door_lock;
    logic       busy;
    logic       done;

    modport master (
        output start, abort, pause, wash, rinse, spin, cloth,
        input  state, remaining, valve_in, motor, spin_hi, drain_pump, door_lock, busy, done
    );

    modport slave (
        input  start, abort, pause, wash, rinse, spin, cloth,
        output state, remaining, valve_in, motor, spin_hi, drain_pump, door_lock, busy, done
    );
endinterface

// File: rtl/wash_cycle_controller.sv
// Wash-cycle sequencer: fill, wash, drain, rinse, drain, spin, with abort through a drain phase.
// Defining WM_PAUSE_EN compiles in the pause freeze; otherwise the pause input is ignored.
module wash_cycle_controller #(
    parameter int unsigned TICK_DIV    = 1,
    parameter int unsigned DRAIN_TICKS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    wash_cycle_controller_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_FILL        = 4'd1,
        S_WASH        = 4'd2,
        S_DRAIN1      = 4'd3,
        S_RINSE       = 4'd4,
        S_DRAIN2      = 4'd5,
        S_SPIN        = 4'd6,
        S_DONE        = 4'd7,
        S_ABORT_DRAIN = 4'd8
    } state_t;

    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);
    localparam logic [4:0] DRAIN_LEN = 5'(DRAIN_TICKS);

    state_t     state_q, state_d, phase_s;
    logic [4:0] remaining_q, remaining_d, phase_len;
    logic [7:0] presc_q, presc_d;
    logic [4:0] wash_q, rinse_q, spin_q, cloth_q;
    logic       snap, tick, frozen, quiet;
    logic [6:0] outs_d, outs_q;  // {valve_in, motor, spin_hi, drain_pump, door_lock, busy, done}
    logic       unused_ok;

    function automatic state_t next_phase(state_t s);
        case (s)
            S_FILL:   return S_WASH;
            S_WASH:   return S_DRAIN1;
            S_DRAIN1: return S_RINSE;
            S_RINSE:  return S_DRAIN2;
            S_DRAIN2: return S_SPIN;
            S_SPIN:   return S_DONE;
            default:  return S_IDLE;
        endcase
    endfunction

    assign phase_s = next_phase(state_q);

    always_comb begin
        case (phase_s)
            S_WASH:             phase_len = wash_q;
            S_RINSE:            phase_len = rinse_q;
            S_SPIN:             phase_len = spin_q;
            S_DRAIN1, S_DRAIN2: phase_len = DRAIN_LEN;
            default:            phase_len = '0;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        remaining_d = remaining_q;
        presc_d     = presc_q;
        snap        = 1'b0;
        frozen      = 1'b0;
`ifdef WM_PAUSE_EN
        frozen = bus.pause && (state_q != S_IDLE) && (state_q != S_DONE);
`endif
        tick = (state_q != S_IDLE) && !frozen && (presc_q == TICK_LAST);
        if ((state_q != S_IDLE) && !frozen) begin
            presc_d = tick ? '0 : presc_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                presc_d = '0;
                // Fill loads the live preset: the snapshot lands on this same edge.
                if (bus.start) begin
                    snap        = 1'b1;
                    state_d     = S_FILL;
                    remaining_d = bus.cloth;
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                remaining_d = '0;
            end
            S_ABORT_DRAIN: begin
                if (tick) begin
                    if (remaining_q <= 5'd1) begin
                        state_d     = S_IDLE;
                        remaining_d = '0;
                    end else begin
                        remaining_d = remaining_q - 5'd1;
                    end
                end
            end
            default: begin
                // Abort outranks the tick, and is honoured even while frozen.
                if (bus.abort) begin
                    state_d     = S_ABORT_DRAIN;
                    remaining_d = DRAIN_LEN;
                end else if (tick) begin
                    if (remaining_q <= 5'd1) begin
                        state_d     = phase_s;
                        remaining_d = phase_len;
                    end else begin
                        remaining_d = remaining_q - 5'd1;
                    end
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copy moves with state.
    always_comb begin
        quiet = 1'b0;
`ifdef WM_PAUSE_EN
        quiet     = bus.pause && (state_d != S_IDLE) && (state_d != S_DONE);
        unused_ok = ^cloth_q;
`else
        unused_ok = ^{cloth_q, bus.pause};
`endif
        case (state_d)
            S_FILL:                           outs_d = 7'b1000110;
            S_WASH:                           outs_d = 7'b0100110;
            S_RINSE:                          outs_d = 7'b1100110;
            S_SPIN:                           outs_d = 7'b0111110;
            S_DRAIN1, S_DRAIN2, S_ABORT_DRAIN: outs_d = 7'b0001110;
            S_DONE:                           outs_d = 7'b0000011;
            default:                          outs_d = 7'b0000000;
        endcase
        if (quiet) begin
            outs_d[6:3] = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            presc_q     <= '0;
            outs_q      <= '0;
            // NOTE: the preset snapshot is reset as well, so no stale preset survives a reset.
            wash_q      <= '0;
            rinse_q     <= '0;
            spin_q      <= '0;
            cloth_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register take its value on the same edge.
            state_q     <= state_d;
            remaining_q <= remaining_d;
            presc_q     <= presc_d;
            outs_q      <= outs_d;
            if (snap) begin
                wash_q  <= bus.wash;
                rinse_q <= bus.rinse;
                spin_q  <= bus.spin;
                cloth_q <= bus.cloth;
            end
        end
    end

    assign bus.state      = state_q;
    assign bus.remaining  = remaining_q;
    assign bus.valve_in   = outs_q[6];
    assign bus.motor      = outs_q[5];
    assign bus.spin_hi    = outs_q[4];
    assign bus.drain_pump = outs_q[3];
    assign bus.door_lock  = outs_q[2];
    assign bus.busy       = outs_q[1];
    assign bus.done       = outs_q[0];
endmodule

// File: tb/tb_wash_cycle_controller.sv
// Directed bench for wash_cycle_controller: one DUT at TICK_DIV=1, one at TICK_DIV=2 for pause.
module tb_wash_cycle_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wash_cycle_controller_if a_if();
    wash_cycle_controller_if b_if();

    wash_cycle_controller #(.TICK_DIV(1), .DRAIN_TICKS(4)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    wash_cycle_controller #(.TICK_DIV(2), .DRAIN_TICKS(4)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_st[$];
    logic [4:0] exp_rem[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Actuator table {valve_in, motor, spin_hi, drain_pump, door_lock, busy, done} by state code.
    function automatic logic [6:0] exp_act(logic [3:0] s);
        case (s)
            4'd1:    return 7'b1000110;
            4'd2:    return 7'b0100110;
            4'd3:    return 7'b0001110;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b0001110;
            4'd6:    return 7'b0111110;
            4'd7:    return 7'b0000011;
            4'd8:    return 7'b0001110;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] act_a();
        return {a_if.valve_in, a_if.motor, a_if.spin_hi, a_if.drain_pump, a_if.door_lock, a_if.busy, a_if.done};
    endfunction

    function automatic logic [6:0] act_b();
        return {b_if.valve_in, b_if.motor, b_if.spin_hi, b_if.drain_pump, b_if.door_lock, b_if.busy, b_if.done};
    endfunction

    task automatic push_phase(logic [3:0] code, logic [4:0] len);
        if (len == 5'd0) begin
            exp_st.push_back(code);
            exp_rem.push_back(5'd0);
        end else begin
            for (int r = int'(len); r >= 1; r--) begin
                exp_st.push_back(code);
                exp_rem.push_back(5'(r));
            end
        end
    endtask

    // Per-cycle (state, remaining) seen on DUT a from the cycle after start is accepted.
    task automatic build_expected(logic [4:0] c, logic [4:0] w, logic [4:0] r, logic [4:0] s);
        exp_st.delete();
        exp_rem.delete();
        push_phase(4'd1, c);
        push_phase(4'd2, w);
        push_phase(4'd3, 5'd4);
        push_phase(4'd4, r);
        push_phase(4'd5, 5'd4);
        push_phase(4'd6, s);
        push_phase(4'd7, 5'd0);
        push_phase(4'd0, 5'd0);
    endtask

    task automatic start_a(logic [4:0] c, logic [4:0] w, logic [4:0] r, logic [4:0] s);
        a_if.cloth = c;
        a_if.wash  = w;
        a_if.rinse = r;
        a_if.spin  = s;
        a_if.start = 1'b1;
        step();
        a_if.start = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        a_if.start = 1'b1;
        step();
        step();
        checks++;
        if (a_if.state !== 4'd0 || a_if.remaining !== 5'd0 || act_a() !== 7'd0) begin
            failures++;
            $display("FAIL reset_a state=%0d rem=%0d act=%b want 0/0/0000000", a_if.state, a_if.remaining, act_a());
        end
        checks++;
        if (b_if.state !== 4'd0 || b_if.remaining !== 5'd0 || act_b() !== 7'd0) begin
            failures++;
            $display("FAIL reset_b state=%0d rem=%0d act=%b want 0/0/0000000", b_if.state, b_if.remaining, act_b());
        end
        a_if.start = 1'b0;
        rst        = 1'b0;
        step();
    endtask

    task automatic test_normal_cycle();
        int busy_cnt = 0;
        int done_cnt = 0;
        build_expected(5'd2, 5'd3, 5'd2, 5'd1);
        start_a(5'd2, 5'd3, 5'd2, 5'd1);
        for (int i = 0; i < exp_st.size(); i++) begin
            if (i == 3) a_if.start = 1'b1;   // must be ignored while busy
            if (i == 4) a_if.start = 1'b0;
            checks++;
            if (a_if.state !== exp_st[i] || a_if.remaining !== exp_rem[i]) begin
                failures++;
                $display("FAIL normal[%0d] state/rem=%0d/%0d want %0d/%0d", i, a_if.state, a_if.remaining, exp_st[i], exp_rem[i]);
            end
            checks++;
            if (act_a() !== exp_act(exp_st[i])) begin
                failures++;
                $display("FAIL normal_act[%0d] act=%b want %b", i, act_a(), exp_act(exp_st[i]));
            end
            if (a_if.busy === 1'b1) busy_cnt++;
            if (a_if.done === 1'b1) done_cnt++;
            if (i < exp_st.size() - 1) step();
        end
        checks++;
        if (busy_cnt != 17 || done_cnt != 1) begin
            failures++;
            $display("FAIL normal_counts busy=%0d done=%0d want 17/1", busy_cnt, done_cnt);
        end
    endtask

    task automatic test_zero_presets();
        int done_at = -1;
        build_expected(5'd0, 5'd0, 5'd0, 5'd0);
        start_a(5'd0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < exp_st.size(); i++) begin
            checks++;
            if (a_if.state !== exp_st[i] || a_if.remaining !== exp_rem[i]) begin
                failures++;
                $display("FAIL zero[%0d] state/rem=%0d/%0d want %0d/%0d", i, a_if.state, a_if.remaining, exp_st[i], exp_rem[i]);
            end
            if (a_if.done === 1'b1 && done_at < 0) done_at = i + 1;
            if (i < exp_st.size() - 1) step();
        end
        checks++;
        if (done_at != 13) begin
            failures++;
            $display("FAIL zero_done_latency got=%0d want 13", done_at);
        end
    endtask

    task automatic test_abort_wash();
        int done_seen = 0;
        start_a(5'd2, 5'd3, 5'd2, 5'd1);
        step();
        step();
        step();
        checks++;
        if (a_if.state !== 4'd2 || a_if.remaining !== 5'd2) begin
            failures++;
            $display("FAIL abort_pre state/rem=%0d/%0d want 2/2", a_if.state, a_if.remaining);
        end
        a_if.abort = 1'b1;
        step();
        a_if.abort = 1'b0;
        checks++;
        if (a_if.state !== 4'd8 || a_if.remaining !== 5'd4 || a_if.drain_pump !== 1'b1 || a_if.motor !== 1'b0) begin
            failures++;
            $display("FAIL abort_entry state/rem/pump=%0d/%0d/%b want 8/4/1", a_if.state, a_if.remaining, a_if.drain_pump);
        end
        for (int k = 0; k < 4; k++) begin
            if (a_if.done === 1'b1) done_seen++;
            step();
        end
        if (a_if.done === 1'b1) done_seen++;
        checks++;
        if (a_if.state !== 4'd0 || a_if.remaining !== 5'd0 || done_seen != 0) begin
            failures++;
            $display("FAIL abort_exit state/rem=%0d/%0d done_seen=%0d want 0/0/0", a_if.state, a_if.remaining, done_seen);
        end
        a_if.abort = 1'b1;
        step();
        a_if.abort = 1'b0;
        checks++;
        if (a_if.state !== 4'd0 || a_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle state=%0d busy=%b want 0/0", a_if.state, a_if.busy);
        end
    endtask

    task automatic test_abort_drain();
        start_a(5'd0, 5'd0, 5'd0, 5'd0);
        step();
        step();
        step();
        checks++;
        if (a_if.state !== 4'd3 || a_if.remaining !== 5'd3) begin
            failures++;
            $display("FAIL abort_d1_pre state/rem=%0d/%0d want 3/3", a_if.state, a_if.remaining);
        end
        a_if.abort = 1'b1;
        step();
        a_if.abort = 1'b0;
        checks++;
        if (a_if.state !== 4'd8 || a_if.remaining !== 5'd4) begin
            failures++;
            $display("FAIL abort_d1_reload state/rem=%0d/%0d want 8/4", a_if.state, a_if.remaining);
        end
        for (int k = 0; k < 4; k++) step();
        checks++;
        if (a_if.state !== 4'd0) begin
            failures++;
            $display("FAIL abort_d1_exit state=%0d want 0", a_if.state);
        end
    endtask

    task automatic test_reset_mid_rinse();
        start_a(5'd1, 5'd1, 5'd3, 5'd1);
        for (int k = 0; k < 7; k++) step();
        checks++;
        if (a_if.state !== 4'd4 || a_if.remaining !== 5'd2) begin
            failures++;
            $display("FAIL rinse_pre state/rem=%0d/%0d want 4/2", a_if.state, a_if.remaining);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (a_if.state !== 4'd0 || a_if.remaining !== 5'd0 || act_a() !== 7'd0) begin
            failures++;
            $display("FAIL rinse_reset state=%0d rem=%0d act=%b want 0/0/0000000", a_if.state, a_if.remaining, act_a());
        end
        build_expected(5'd3, 5'd1, 5'd1, 5'd1);
        start_a(5'd3, 5'd1, 5'd1, 5'd1);
        for (int i = 0; i < exp_st.size(); i++) begin
            checks++;
            if (a_if.state !== exp_st[i] || a_if.remaining !== exp_rem[i] || act_a() !== exp_act(exp_st[i])) begin
                failures++;
                $display("FAIL restart[%0d] state/rem=%0d/%0d want %0d/%0d", i, a_if.state, a_if.remaining, exp_st[i], exp_rem[i]);
            end
            if (i < exp_st.size() - 1) step();
        end
    endtask

    task automatic test_snapshot();
        build_expected(5'd5, 5'd5, 5'd5, 5'd5);
        start_a(5'd5, 5'd5, 5'd5, 5'd5);
        for (int i = 0; i < exp_st.size(); i++) begin
            if (i == 5) begin
                a_if.cloth = 5'd9;
                a_if.wash  = 5'd9;
                a_if.rinse = 5'd9;
                a_if.spin  = 5'd9;
            end
            checks++;
            if (a_if.state !== exp_st[i] || a_if.remaining !== exp_rem[i]) begin
                failures++;
                $display("FAIL snap5[%0d] state/rem=%0d/%0d want %0d/%0d", i, a_if.state, a_if.remaining, exp_st[i], exp_rem[i]);
            end
            if (i < exp_st.size() - 1) step();
        end
        build_expected(5'd9, 5'd9, 5'd9, 5'd9);
        start_a(5'd9, 5'd9, 5'd9, 5'd9);
        for (int i = 0; i < exp_st.size(); i++) begin
            checks++;
            if (a_if.state !== exp_st[i] || a_if.remaining !== exp_rem[i]) begin
                failures++;
                $display("FAIL snap9[%0d] state/rem=%0d/%0d want %0d/%0d", i, a_if.state, a_if.remaining, exp_st[i], exp_rem[i]);
            end
            if (i < exp_st.size() - 1) step();
        end
    endtask

    task automatic test_pause();
        logic [4:0] rem_tab [5] = '{5'd3, 5'd2, 5'd2, 5'd1, 5'd1};
        logic [4:0] exp_r;
        logic       exp_m;
        b_if.cloth = 5'd1;
        b_if.wash  = 5'd4;
        b_if.rinse = 5'd1;
        b_if.spin  = 5'd1;
        b_if.start = 1'b1;
        step();
        b_if.start = 1'b0;
        for (int k = 0; k < 4; k++) step();
        checks++;
        if (b_if.state !== 4'd2 || b_if.remaining !== 5'd3) begin
            failures++;
            $display("FAIL pause_pre state/rem=%0d/%0d want 2/3", b_if.state, b_if.remaining);
        end
        b_if.pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
`ifdef WM_PAUSE_EN
            exp_r = 5'd3;
            exp_m = 1'b0;
`else
            exp_r = rem_tab[k];
            exp_m = 1'b1;
`endif
            checks++;
            if (b_if.state !== 4'd2 || b_if.remaining !== exp_r || b_if.motor !== exp_m || b_if.door_lock !== 1'b1) begin
                failures++;
                $display("FAIL pause[%0d] state/rem/motor/lock=%0d/%0d/%b/%b want 2/%0d/%b/1", k, b_if.state, b_if.remaining, b_if.motor, b_if.door_lock, exp_r, exp_m);
            end
        end
        b_if.pause = 1'b0;
`ifdef WM_PAUSE_EN
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (b_if.state !== 4'd2 || b_if.remaining !== rem_tab[k] || b_if.motor !== 1'b1) begin
                failures++;
                $display("FAIL resume[%0d] state/rem/motor=%0d/%0d/%b want 2/%0d/1", k, b_if.state, b_if.remaining, b_if.motor, rem_tab[k]);
            end
        end
`endif
        step();
        checks++;
        if (b_if.state !== 4'd3 || b_if.remaining !== 5'd4) begin
            failures++;
            $display("FAIL pause_exit state/rem=%0d/%0d want 3/4", b_if.state, b_if.remaining);
        end
    endtask

    initial begin
        a_if.start = 1'b0; a_if.abort = 1'b0; a_if.pause = 1'b0;
        a_if.wash  = '0;   a_if.rinse = '0;   a_if.spin  = '0; a_if.cloth = '0;
        b_if.start = 1'b0; b_if.abort = 1'b0; b_if.pause = 1'b0;
        b_if.wash  = '0;   b_if.rinse = '0;   b_if.spin  = '0; b_if.cloth = '0;
        rst = 1'b1;
        test_reset();
        test_normal_cycle();
        test_zero_presets();
        test_abort_wash();
        test_abort_drain();
        test_reset_mid_rinse();
        test_snapshot();
        test_pause();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
